// File: rtl/nibble_seq_pkg.sv
// Shared encodings and default pattern constants for the nibble sequence detector.
package nibble_seq_pkg;

  localparam int unsigned NIB_W     = 4;
  localparam int unsigned STATE_W   = 2;
  localparam int unsigned CNT_W_DEF = 8;

  // 2'd3 is never entered; the FSM decodes it like IDLE.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    GOT0 = 2'd1,
    GOT1 = 2'd2
  } state_t;

  localparam logic [NIB_W-1:0] PAT0_DEF = 4'hA;
  localparam logic [NIB_W-1:0] PAT1_DEF = 4'hC;
  localparam logic [NIB_W-1:0] PAT2_DEF = 4'hF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nibble_seq_detector.sv
// Detects the qualified nibble sequence P0,P1,P2 and pulses a registered match,
// counting matches in a saturating counter.
module nibble_seq_detector
  import nibble_seq_pkg::*;
#(
  parameter int unsigned  W     = NIB_W,
  parameter logic [W-1:0] P0    = W'(PAT0_DEF),
  parameter logic [W-1:0] P1    = W'(PAT1_DEF),
  parameter logic [W-1:0] P2    = W'(PAT2_DEF),
  parameter int unsigned  CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [W-1:0]       d,
  input  logic               clr_cnt,
  output logic               match,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   match_cnt
);

  state_t state_q;
  state_t state_d;
  logic   match_d;

  // State and match registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      match   <= 1'b0;
    end else begin
      state_q <= state_d;
      match   <= match_d;
    end
  end

  // Fixed fallback: any miss restarts at GOT0 if the nibble is P0, else IDLE.
  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    if (en) begin
      case (state_q)
        GOT0: begin
          if (d == P1) begin
            state_d = GOT1;
          end else if (d == P0) begin
            state_d = GOT0;
          end else begin
            state_d = IDLE;
          end
        end
        GOT1: begin
          if (d == P2) begin
            match_d = 1'b1;
            state_d = (P2 == P0) ? GOT0 : IDLE;
          end else if (d == P0) begin
            state_d = GOT0;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = (d == P0) ? GOT0 : IDLE;
        end
      endcase
    end
  end

  assign state_o = state_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (match_d),
    .clr  (clr_cnt),
    .cnt  (match_cnt)
  );

endmodule

// File: tb/tb_nibble_seq_detector.sv
// Bench for nibble_seq_detector: three configurations checked against a
// sliding-window model of the qualified sample history.
module tb_nibble_seq_detector;

  localparam logic [3:0] PA = 4'hA;
  localparam logic [3:0] PC = 4'hC;
  localparam logic [3:0] PF = 4'hF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rstn;
  logic [2:0] en;
  logic [2:0] clr;
  logic [3:0] d [3];
  logic [2:0] m;
  logic [1:0] st [3];
  logic [7:0] c0;
  logic [7:0] c1;
  logic [1:0] c2;

  int total = 0;
  int bad   = 0;

  // Instance 0: defaults. Instance 1: P2 = A. Instance 2: 2-bit counter.
  nibble_seq_detector u_dut0 (
    .clk(clk), .rst_n(rstn[0]), .en(en[0]), .d(d[0]), .clr_cnt(clr[0]),
    .match(m[0]), .state_o(st[0]), .match_cnt(c0)
  );
  nibble_seq_detector #(.P2(4'hA)) u_dut1 (
    .clk(clk), .rst_n(rstn[1]), .en(en[1]), .d(d[1]), .clr_cnt(clr[1]),
    .match(m[1]), .state_o(st[1]), .match_cnt(c1)
  );
  nibble_seq_detector #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rstn[2]), .en(en[2]), .d(d[2]), .clr_cnt(clr[2]),
    .match(m[2]), .state_o(st[2]), .match_cnt(c2)
  );

  // Model: last three qualified samples since reset, expected match and count.
  logic [3:0] h [3][3];
  int         n [3];
  int         ec [3];
  bit         em [3];
  logic [3:0] p2 [3];
  int         cmax [3];

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int exp_state(input int i);
    if (n[i] >= 2 && h[i][1] == PA && h[i][0] == PC) return 2;
    if (n[i] >= 1 && h[i][0] == PA) return 1;
    return 0;
  endfunction

  function automatic int act_cnt(input int i);
    case (i)
      0:       return int'(c0);
      1:       return int'(c1);
      default: return int'(c2);
    endcase
  endfunction

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (!rstn[i]) begin
        n[i]  = 0;
        em[i] = 1'b0;
        ec[i] = 0;
      end else begin
        em[i] = 1'b0;
        if (en[i]) begin
          h[i][2] = h[i][1];
          h[i][1] = h[i][0];
          h[i][0] = d[i];
          n[i]    = (n[i] < 3) ? n[i] + 1 : 3;
          if (n[i] == 3 && h[i][2] == PA && h[i][1] == PC && h[i][0] == p2[i])
            em[i] = 1'b1;
        end
        if (clr[i]) ec[i] = 0;
        else if (em[i] && ec[i] < cmax[i]) ec[i] = ec[i] + 1;
      end
    end
  endtask

  // Advance one edge and compare every instance against the model.
  task automatic tick();
    model_step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("match%0d", i), int'(m[i]), int'(em[i]));
      chk($sformatf("state%0d", i), int'(st[i]), exp_state(i));
      chk($sformatf("cnt%0d", i), act_cnt(i), ec[i]);
    end
  endtask

  task automatic drive(input int i, input bit e, input logic [3:0] dv,
                       input bit c, input bit r);
    rstn  = '1;
    en    = '0;
    clr   = '0;
    rstn[i] = r;
    en[i]   = e;
    clr[i]  = c;
    d[i]    = dv;
    tick();
  endtask

  task automatic acf(input int i);
    drive(i, 1'b1, PA, 1'b0, 1'b1);
    drive(i, 1'b1, PC, 1'b0, 1'b1);
    drive(i, 1'b1, PF, 1'b0, 1'b1);
  endtask

  int exp_sat [5];

  initial begin
    p2   = '{PF, PA, PF};
    cmax = '{255, 255, 3};
    exp_sat = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 3; i++) begin
      n[i] = 0; ec[i] = 0; em[i] = 1'b0; d[i] = 4'h0;
      for (int k = 0; k < 3; k++) h[i][k] = 4'h0;
    end
    rstn = '0; en = '0; clr = '0;
    tick();
    tick();
    chk("rst_match0", int'(m[0]), 0);
    chk("rst_state0", int'(st[0]), 0);
    chk("rst_cnt0", int'(c0), 0);
    chk("rst_cnt2", int'(c2), 0);

    // A,C,F
    drive(0, 1'b1, PA, 1'b0, 1'b1);
    drive(0, 1'b1, PC, 1'b0, 1'b1);
    chk("acf_state_got1", int'(st[0]), 2);
    drive(0, 1'b1, PF, 1'b0, 1'b1);
    chk("acf_match", int'(m[0]), 1);
    chk("acf_cnt", int'(c0), 1);
    chk("acf_state_idle", int'(st[0]), 0);
    drive(0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("acf_pulse_one_cycle", int'(m[0]), 0);

    // A,A,C,F
    drive(0, 1'b1, PA, 1'b0, 1'b1);
    acf(0);
    chk("aacf_cnt", int'(c0), 2);

    // A,C,A,C,F
    drive(0, 1'b1, PA, 1'b0, 1'b1);
    drive(0, 1'b1, PC, 1'b0, 1'b1);
    acf(0);
    chk("acacf_cnt", int'(c0), 3);

    // A,C,0,F: no match
    drive(0, 1'b1, PA, 1'b0, 1'b1);
    drive(0, 1'b1, PC, 1'b0, 1'b1);
    drive(0, 1'b1, 4'h0, 1'b0, 1'b1);
    drive(0, 1'b1, PF, 1'b0, 1'b1);
    chk("ac0f_match", int'(m[0]), 0);
    chk("ac0f_cnt", int'(c0), 3);

    // A,C,F with disabled gaps carrying 5
    drive(0, 1'b1, PA, 1'b0, 1'b1);
    drive(0, 1'b0, 4'h5, 1'b0, 1'b1);
    drive(0, 1'b1, PC, 1'b0, 1'b1);
    drive(0, 1'b0, 4'h5, 1'b0, 1'b1);
    drive(0, 1'b0, 4'h5, 1'b0, 1'b1);
    chk("gap_state_hold", int'(st[0]), 2);
    drive(0, 1'b1, PF, 1'b0, 1'b1);
    chk("gap_match", int'(m[0]), 1);
    chk("gap_cnt", int'(c0), 4);

    // P2 = A re-entry: A,C,A,C,A
    drive(1, 1'b1, PA, 1'b0, 1'b1);
    drive(1, 1'b1, PC, 1'b0, 1'b1);
    drive(1, 1'b1, PA, 1'b0, 1'b1);
    chk("reent_match1", int'(m[1]), 1);
    chk("reent_state", int'(st[1]), 1);
    drive(1, 1'b1, PC, 1'b0, 1'b1);
    chk("reent_gap", int'(m[1]), 0);
    drive(1, 1'b1, PA, 1'b0, 1'b1);
    chk("reent_match2", int'(m[1]), 1);
    chk("reent_cnt", int'(c1), 2);

    // Saturation with CNT_W = 2, then clear beating increment
    for (int k = 0; k < 5; k++) begin
      acf(2);
      chk($sformatf("sat_cnt_%0d", k), int'(c2), exp_sat[k]);
    end
    drive(2, 1'b1, PA, 1'b0, 1'b1);
    drive(2, 1'b1, PC, 1'b0, 1'b1);
    drive(2, 1'b1, PF, 1'b1, 1'b1);
    chk("clr_match", int'(m[2]), 1);
    chk("clr_cnt", int'(c2), 0);

    // Reset mid-sequence discards progress
    drive(0, 1'b1, PA, 1'b0, 1'b1);
    drive(0, 1'b1, PC, 1'b0, 1'b1);
    drive(0, 1'b1, PF, 1'b0, 1'b0);
    chk("midrst_state", int'(st[0]), 0);
    chk("midrst_cnt", int'(c0), 0);
    drive(0, 1'b1, PF, 1'b0, 1'b1);
    chk("midrst_match", int'(m[0]), 0);
    chk("midrst_state2", int'(st[0]), 0);

    // Randomized traffic on all instances
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < 3; i++) begin
        int r;
        rstn[i] = ($urandom_range(0, 199) != 0);
        en[i]   = ($urandom_range(0, 3) != 0);
        clr[i]  = ($urandom_range(0, 63) == 0);
        r = int'($urandom_range(0, 7));
        if (r < 2)      d[i] = PA;
        else if (r < 4) d[i] = PC;
        else if (r < 6) d[i] = PF;
        else            d[i] = 4'($urandom_range(0, 15));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
